chaos_cipher_engine: RTL and testbench

Parametrised confusion/diffusion engine for the Lorenz chaotic image cipher. It consumes a chaotic key stream, one word per element, and applies one pass to an external single-port image RAM. Each pass is one of: swap-permutation, chained-XOR diffusion, or plain-XOR diffusion. It supports encrypt and decrypt, and sits between the Lorenz key-stream generator and the image RAM.

---
 rtl/chaos_pkg.sv | 26 ++
 rtl/chaos_cipher_engine.sv | 168 ++++++++++++++++
 tb/tb_chaos_cipher_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/chaos_pkg.sv
// Shared encodings for the chaotic cipher engine: pass modes, FSM states and RAM timing.
package chaos_pkg;

  localparam logic [1:0] MODE_SWAP      = 2'd0;
  localparam logic [1:0] MODE_XOR_CHAIN = 2'd1;
  localparam logic [1:0] MODE_XOR_PLAIN = 2'd2;
  localparam logic [1:0] MODE_RSVD      = 2'd3;

  // Image RAM returns read data this many cycles after the address is presented.
  localparam int RD_LAT = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KS,
    ST_RD_I,
    ST_RD_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_X_RD,
    ST_X_CAP,
    ST_X_WR,
    ST_FIN
  } state_t;

endpackage

// File: rtl/chaos_cipher_engine.sv
// Confusion/diffusion pass engine: consumes one key word per image element and
// applies a swap permutation or XOR diffusion in place on a single-port RAM.
module chaos_cipher_engine
  import chaos_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int KEY_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              decrypt,
  input  logic [DATA_W-1:0] iv,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [KEY_W-1:0]  ks_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE_IDX  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     i_q, i_d;
  logic [1:0]          mode_q;
  logic                dec_q;
  logic [KEY_W-1:0]    k_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   chain_q;

  logic                busy_d, done_d, err_d, we_d, ks_ready_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   xor_w;
  logic                swap_dec, last_elem;

  function automatic logic [DATA_W-1:0] xor_word(input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] k,
                                                 input logic [DATA_W-1:0] c,
                                                 input logic              chained);
    return chained ? (r ^ k ^ c) : (r ^ k);
  endfunction

  assign xor_w     = xor_word(mem_rdata, k_q[DATA_W-1:0], chain_q, mode_q == MODE_XOR_CHAIN);
  assign swap_dec  = (mode_q == MODE_SWAP) && dec_q;
  assign last_elem = swap_dec ? (i_q == '0) : (i_q == LAST_IDX);

  // Next state and next registered outputs; outputs describe the state being entered.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    we_d       = 1'b0;
    ks_ready_d = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = (mode == MODE_RSVD);
          if (mode == MODE_RSVD) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = ST_KS;
            busy_d     = 1'b1;
            ks_ready_d = 1'b1;
            i_d        = (mode == MODE_SWAP && decrypt) ? LAST_IDX : '0;
          end
        end
      end
      ST_KS: begin
        if (ks_valid) begin
          state_d = (mode_q == MODE_SWAP) ? ST_RD_I : ST_X_RD;
          addr_d  = i_q[ADDR_W-1:0];
        end else begin
          ks_ready_d = 1'b1;
        end
      end
      ST_RD_I: begin
        state_d = ST_RD_J;
        addr_d  = k_q[ADDR_W-1:0];
      end
      ST_RD_J: state_d = ST_CAP_J;
      ST_CAP_J: begin
        state_d = ST_WR_I;
        addr_d  = i_q[ADDR_W-1:0];
        wdata_d = mem_rdata;
        we_d    = 1'b1;
      end
      ST_WR_I: begin
        state_d = ST_WR_J;
        addr_d  = k_q[ADDR_W-1:0];
        wdata_d = a_q;
        we_d    = 1'b1;
      end
      ST_X_RD: state_d = ST_X_CAP;
      ST_X_CAP: begin
        state_d = ST_X_WR;
        addr_d  = i_q[ADDR_W-1:0];
        wdata_d = xor_w;
        we_d    = 1'b1;
      end
      ST_WR_J, ST_X_WR: begin
        if (last_elem) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d    = ST_KS;
          ks_ready_d = 1'b1;
          i_d        = swap_dec ? (i_q - ONE_IDX) : (i_q + ONE_IDX);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      ks_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mem_we    <= we_d;
      ks_ready  <= ks_ready_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // Datapath holds no reset; every register is loaded before it is read in a pass.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      mode_q  <= mode;
      dec_q   <= decrypt;
      chain_q <= iv;
    end
    if (state_q == ST_KS && ks_valid) k_q <= ks_data;
    if (state_q == ST_RD_J) a_q <= mem_rdata;
    // Chain always follows the ciphertext side of the element just processed.
    if (state_q == ST_X_CAP) chain_q <= dec_q ? mem_rdata : xor_w;
  end

endmodule

// File: tb/tb_chaos_cipher_engine.sv
// Directed bench for chaos_cipher_engine on an 8-word, 8-bit image RAM.
module tb_chaos_cipher_engine;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int KW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          decrypt;
  logic [DW-1:0] iv;
  logic          ks_valid = 1'b0;
  logic          ks_ready;
  logic [KW-1:0] ks_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, err;

  logic [DW-1:0] ram  [N];
  logic [DW-1:0] orig [N];
  logic [DW-1:0] expv [N];
  logic [KW-1:0] keys [N];
  logic [KW-1:0] rkeys[N];
  int            kidx = 0;
  int            stall_elem = -1;
  int            stall_left = 0;
  int            we_cnt = 0;
  bit            stall_we_bad = 0;
  bit            hs_seen;
  int            n_vec = 0;
  int            n_bad = 0;

  chaos_cipher_engine #(.DATA_W(DW), .ADDR_W(AW), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .decrypt(decrypt), .iv(iv),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Key-stream producer: advances on each handshake, optionally withholds one word.
  always @(posedge clk) begin
    hs_seen = ks_valid && ks_ready;
    #1;
    if (hs_seen) kidx++;
    if (kidx < N) ks_data = keys[kidx[AW-1:0]];
    if (stall_left > 0 && kidx == stall_elem && ks_ready) begin
      ks_valid = 1'b0;
      stall_left--;
    end else begin
      ks_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (!ks_valid && mem_we) stall_we_bad = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_pass(input logic [1:0] m, input logic d, input logic [DW-1:0] v,
                          input bit poke_busy, output int cyc, output int ndone,
                          output logic err_at_done);
    @(negedge clk);
    start = 1'b1; mode = m; decrypt = d; iv = v; kidx = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (poke_busy && cyc == 3) begin
        start = 1'b1; mode = 2'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    ndone = done ? 1 : 0;
    err_at_done = err;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), 32'(ram[i]), 32'(expv[i]));
  endtask

  int   cyc, nd, we0, t;
  logic e;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; decrypt = 1'b0; iv = '0;
    for (int i = 0; i < N; i++) begin ram[i] = '0; keys[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ks_ready", 32'(ks_ready), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    // SWAP encrypt, identity image, zero keys, with an ignored start while busy
    for (int i = 0; i < N; i++) begin ram[i] = DW'(i); keys[i] = '0; end
    expv[0] = 8'd7;
    for (int i = 1; i < N; i++) expv[i] = DW'(i - 1);
    run_pass(2'd0, 1'b0, '0, 1'b1, cyc, nd, e);
    check_ram("swap_enc");
    chk("swap_done_cycle", 32'(cyc), 32'd49);
    chk("swap_ndone", 32'(nd), 32'd1);
    chk("swap_err", 32'(e), 32'd0);

    // Reserved mode
    we0 = we_cnt;
    run_pass(2'd3, 1'b0, '0, 1'b0, cyc, nd, e);
    chk("rsvd_done_cycle", 32'(cyc), 32'd1);
    chk("rsvd_err_at_done", 32'(e), 32'd1);
    chk("rsvd_err_sticky", 32'(err), 32'd1);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_no_write", 32'(we_cnt - we0), 32'd0);

    // SWAP round trip with random keys and image
    for (int i = 0; i < N; i++) begin
      orig[i] = DW'($urandom_range(0, 255));
      keys[i] = KW'($urandom_range(0, 255));
      ram[i]  = orig[i];
      expv[i] = orig[i];
    end
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] tmp;
      logic [AW-1:0] j;
      j = keys[i][AW-1:0];
      tmp = expv[i]; expv[i] = expv[j]; expv[j] = tmp;
    end
    run_pass(2'd0, 1'b0, '0, 1'b0, cyc, nd, e);
    chk("rt_err_cleared", 32'(e), 32'd0);
    check_ram("rt_enc");
    for (int i = 0; i < N; i++) rkeys[i] = keys[N-1-i];
    for (int i = 0; i < N; i++) begin keys[i] = rkeys[i]; expv[i] = orig[i]; end
    run_pass(2'd0, 1'b1, '0, 1'b0, cyc, nd, e);
    check_ram("rt_dec");
    chk("rt_dec_cycle", 32'(cyc), 32'd49);

    // XOR_CHAIN encrypt and decrypt
    for (int i = 0; i < N; i++) begin ram[i] = '0; keys[i] = 8'h01; expv[i] = (i % 2 == 0) ? 8'h01 : 8'h00; end
    run_pass(2'd1, 1'b0, 8'h00, 1'b0, cyc, nd, e);
    check_ram("chain_enc");
    chk("chain_done_cycle", 32'(cyc), 32'd33);
    for (int i = 0; i < N; i++) expv[i] = 8'h00;
    run_pass(2'd1, 1'b1, 8'h00, 1'b0, cyc, nd, e);
    check_ram("chain_dec");

    // XOR_PLAIN without and with a 5-cycle key-stream stall
    for (int i = 0; i < N; i++) begin
      orig[i] = DW'(i * 17);
      keys[i] = KW'(i * 3 + 5);
      ram[i]  = orig[i];
      expv[i] = orig[i] ^ keys[i];
    end
    run_pass(2'd2, 1'b0, 8'hA5, 1'b0, cyc, nd, e);
    check_ram("plain");
    chk("plain_done_cycle", 32'(cyc), 32'd33);
    for (int i = 0; i < N; i++) ram[i] = orig[i];
    stall_we_bad = 0;
    stall_elem = 3; stall_left = 5;
    run_pass(2'd2, 1'b0, 8'hA5, 1'b0, cyc, nd, e);
    check_ram("plain_stall");
    chk("stall_done_cycle", 32'(cyc), 32'd38);
    chk("stall_we_low", 32'(stall_we_bad), 32'd0);
    chk("stall_consumed", 32'(stall_left), 32'd0);
    stall_elem = -1;

    // Reset while in WR_I, then a clean pass
    for (int i = 0; i < N; i++) begin ram[i] = DW'(i); keys[i] = '0; end
    @(negedge clk);
    start = 1'b1; mode = 2'd0; decrypt = 1'b0; kidx = 0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!mem_we && t < 100) begin @(negedge clk); t++; end
    chk("rst_reach_wr_i", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ks_ready", 32'(ks_ready), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    we0 = we_cnt;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_write", 32'(we_cnt - we0), 32'd0);
    for (int i = 0; i < N; i++) ram[i] = DW'(i);
    expv[0] = 8'd7;
    for (int i = 1; i < N; i++) expv[i] = DW'(i - 1);
    run_pass(2'd0, 1'b0, '0, 1'b0, cyc, nd, e);
    check_ram("post_rst");
    chk("post_rst_cycle", 32'(cyc), 32'd49);
    chk("post_rst_ndone", 32'(nd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
